// File: rtl/snn_seq_ctrl_if.sv
// Bus bundle for the inference sequencer: UART rx/tx handshakes, input-RAM port and snn_core control.
// The master side is the sequencer itself; the slave side is everything around it.
interface snn_seq_ctrl_if #(
  parameter int ADDR_WIDTH = 10
);
  logic                  rx_rdy;
  logic [7:0]            rx_data;
  logic [ADDR_WIDTH-1:0] core_addr;
  logic                  core_done;
  logic [3:0]            core_digit;
  logic                  tx_busy;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic                  ram_d;
  logic                  core_start;
  logic                  tx_start;
  logic [7:0]            tx_data;
  logic                  busy;
  logic                  overrun;

  modport master (
    input  rx_rdy, rx_data, core_addr, core_done, core_digit, tx_busy,
    output ram_we, ram_addr, ram_d, core_start, tx_start, tx_data, busy, overrun
  );

  modport slave (
    output rx_rdy, rx_data, core_addr, core_done, core_digit, tx_busy,
    input  ram_we, ram_addr, ram_d, core_start, tx_start, tx_data, busy, overrun
  );
endinterface

// File: rtl/snn_seq_ctrl.sv
// Image-inference sequencer: unpacks UART bytes MSB-first into the pixel RAM, kicks snn_core,
// then sends the classified digit back as ASCII.
module snn_seq_ctrl #(
  parameter int NUM_PIXELS = 784,
  parameter int ADDR_WIDTH = 10
) (
  input  logic           clk,
  input  logic           rst_n,
  snn_seq_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    WAIT_B,
    START,
    COMPUTE,
    XMIT
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_PIX = ADDR_WIDTH'(NUM_PIXELS - 1);

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_pixCnt;
  logic [7:0]            r_shreg;
  logic [2:0]            r_bitCnt;
  logic [3:0]            r_digit;
  logic                  r_coreStart;
  logic                  r_overrun;

  logic w_shifting;
  logic w_rxDropped;

  assign w_shifting  = (r_state == SHIFT);
  // Bytes can only be absorbed while waiting for one; anything else is lost and flagged.
  assign w_rxDropped = bus.rx_rdy && (r_state inside {SHIFT, START, COMPUTE, XMIT});

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_pixCnt    <= '0;
      r_shreg     <= '0;
      r_bitCnt    <= '0;
      r_digit     <= '0;
      r_coreStart <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_coreStart <= 1'b0;
      if (w_rxDropped) begin
        r_overrun <= 1'b1;
      end
      case (r_state)
        IDLE, WAIT_B: begin
          if (bus.rx_rdy) begin
            r_shreg  <= bus.rx_data;
            r_bitCnt <= '0;
            r_state  <= SHIFT;
          end
        end
        SHIFT: begin
          r_shreg  <= {r_shreg[6:0], 1'b0};
          r_bitCnt <= r_bitCnt + 3'd1;
          if (r_bitCnt == 3'd7) begin
            if (r_pixCnt == LAST_PIX) begin
              r_pixCnt    <= '0;
              r_coreStart <= 1'b1;
              r_state     <= START;
            end else begin
              r_pixCnt <= r_pixCnt + 1'b1;
              r_state  <= WAIT_B;
            end
          end else begin
            r_pixCnt <= r_pixCnt + 1'b1;
          end
        end
        START: begin
          r_state <= COMPUTE;
        end
        COMPUTE: begin
          if (bus.core_done) begin
            r_digit <= bus.core_digit;
            r_state <= XMIT;
          end
        end
        XMIT: begin
          if (!bus.tx_busy) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // tx_start follows tx_busy directly so the pulse lands on the first free cycle.
  assign bus.tx_start   = (r_state == XMIT) && !bus.tx_busy;
  assign bus.tx_data    = {4'h3, r_digit};
  assign bus.ram_we     = w_shifting;
  assign bus.ram_d      = w_shifting && r_shreg[7];
  assign bus.ram_addr   = w_shifting ? r_pixCnt : bus.core_addr;
  assign bus.core_start = r_coreStart;
  assign bus.busy       = (r_state != IDLE);
  assign bus.overrun    = r_overrun;

endmodule

// File: tb/tb_snn_seq_ctrl.sv
// Randomized bench for snn_seq_ctrl: a byte-level image model predicts every RAM write,
// which bytes are dropped, the core_start pulse and the ASCII result.
module tb_snn_seq_ctrl;
  localparam int NUM_PIXELS = 784;
  localparam int NBYTES     = NUM_PIXELS / 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  snn_seq_ctrl_if #(.ADDR_WIDTH(10)) ifc ();

  snn_seq_ctrl #(
    .NUM_PIXELS(NUM_PIXELS),
    .ADDR_WIDTH(10)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifc)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] wrAddr[$];
  logic [31:0] wrData[$];
  int          wrCyc[$];
  int          csCyc[$];
  int          txCyc[$];
  logic [7:0]  txByte[$];

  // Observed-activity log, sampled mid-cycle.
  always @(negedge clk) begin
    if (ifc.ram_we === 1'b1) begin
      wrAddr.push_back(32'(ifc.ram_addr));
      wrData.push_back(32'(ifc.ram_d));
      wrCyc.push_back(cyc);
    end
    if (ifc.core_start === 1'b1) csCyc.push_back(cyc);
    if (ifc.tx_start === 1'b1) begin
      txCyc.push_back(cyc);
      txByte.push_back(ifc.tx_data);
    end
  end

  // Reference model: accepted bytes of the current image and the sticky drop flag.
  logic [7:0] imgBytes[$];
  int         lastAcceptCyc;
  bit         modelProcessing;
  logic       modelOverrun;
  int         lastDriveCyc;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic expPix(input int k);
    logic [7:0] b;
    b = imgBytes[k / 8];
    return b[7 - (k % 8)];
  endfunction

  task automatic modelReset();
    imgBytes.delete();
    lastAcceptCyc   = -1000;
    modelProcessing = 0;
    modelOverrun    = 1'b0;
  endtask

  task automatic clearLog();
    wrAddr.delete();
    wrData.delete();
    wrCyc.delete();
    csCyc.delete();
    txCyc.delete();
    txByte.delete();
  endtask

  // A byte is absorbed only if the previous one has finished its 8 write cycles and no
  // image is being classified or reported.
  task automatic applyStimulus(input logic [7:0] b, input int gap);
    lastDriveCyc = cyc;
    if (!modelProcessing && (cyc - lastAcceptCyc >= 9)) begin
      imgBytes.push_back(b);
      lastAcceptCyc = cyc;
      if (imgBytes.size() == NBYTES) modelProcessing = 1;
    end else begin
      modelOverrun = 1'b1;
    end
    ifc.rx_rdy  = 1'b1;
    ifc.rx_data = b;
    tick();
    ifc.rx_rdy  = 1'b0;
    ifc.rx_data = 8'($urandom);
    repeat (gap - 1) tick();
  endtask

  task automatic feedUntil(input int nBytes);
    while (imgBytes.size() < nBytes) applyStimulus(8'($urandom), int'($urandom_range(9, 13)));
  endtask

  task automatic checkResetState(input string tag);
    @(negedge clk);
    checkOutput({tag, "_busy"}, 32'(ifc.busy), 0);
    checkOutput({tag, "_ram_we"}, 32'(ifc.ram_we), 0);
    checkOutput({tag, "_core_start"}, 32'(ifc.core_start), 0);
    checkOutput({tag, "_tx_start"}, 32'(ifc.tx_start), 0);
    checkOutput({tag, "_tx_data"}, 32'(ifc.tx_data), 32'h30);
    checkOutput({tag, "_overrun"}, 32'(ifc.overrun), 0);
    checkOutput({tag, "_ram_addr"}, 32'(ifc.ram_addr), 32'(ifc.core_addr));
  endtask

  task automatic verifyImageLog(input string tag);
    int n;
    n = imgBytes.size() * 8;
    checkOutput({tag, "_write_count"}, 32'(wrAddr.size()), 32'(n));
    for (int k = 0; k < n && k < wrAddr.size(); k++) begin
      checkOutput({tag, "_wr_addr"}, wrAddr[k], 32'(k));
      checkOutput({tag, "_wr_data"}, wrData[k], 32'(expPix(k)));
    end
  endtask

  task automatic finishImage(input string tag, input logic [3:0] digit, input int hold, input bit stray);
    int budget;
    int tCyc;
    budget = 0;
    while (csCyc.size() == 0 && budget < 300) begin
      tick();
      budget++;
    end
    tick();
    checkOutput({tag, "_core_start_count"}, 32'(csCyc.size()), 1);
    if (csCyc.size() != 0 && wrCyc.size() != 0)
      checkOutput({tag, "_core_start_cycle"}, 32'(csCyc[0]), 32'(wrCyc[wrCyc.size()-1] + 1));
    verifyImageLog(tag);
    if (stray) begin
      applyStimulus(8'($urandom), 2);
      @(negedge clk);
      checkOutput({tag, "_overrun_compute"}, 32'(ifc.overrun), 32'(modelOverrun));
      tick();
    end
    repeat (3) begin
      ifc.core_addr = 10'($urandom_range(0, 1023));
      @(negedge clk);
      checkOutput({tag, "_compute_addr"}, 32'(ifc.ram_addr), 32'(ifc.core_addr));
      checkOutput({tag, "_compute_we"}, 32'(ifc.ram_we), 0);
      tick();
    end
    checkOutput({tag, "_no_tx_early"}, 32'(txCyc.size()), 0);
    ifc.tx_busy    = (hold > 0);
    ifc.core_digit = digit;
    ifc.core_done  = 1'b1;
    tick();
    ifc.core_done  = 1'b0;
    ifc.core_digit = 4'($urandom_range(0, 9));
    repeat (hold) tick();
    checkOutput({tag, "_tx_held"}, 32'(txCyc.size()), 0);
    ifc.tx_busy = 1'b0;
    tCyc = cyc;
    @(negedge clk);
    checkOutput({tag, "_tx_start"}, 32'(ifc.tx_start), 1);
    checkOutput({tag, "_tx_data"}, 32'(ifc.tx_data), 32'({4'h3, digit}));
    tick();
    @(negedge clk);
    checkOutput({tag, "_busy_after_tx"}, 32'(ifc.busy), 0);
    repeat (4) tick();
    checkOutput({tag, "_tx_pulses"}, 32'(txCyc.size()), 1);
    if (txCyc.size() != 0) begin
      checkOutput({tag, "_tx_cycle"}, 32'(txCyc[0]), 32'(tCyc));
      checkOutput({tag, "_tx_byte"}, 32'(txByte[0]), 32'({4'h3, digit}));
    end
    checkOutput({tag, "_overrun_end"}, 32'(ifc.overrun), 32'(modelOverrun));
    imgBytes.delete();
    modelProcessing = 0;
    clearLog();
  endtask

  initial begin
    ifc.rx_rdy     = 1'b0;
    ifc.rx_data    = 8'h00;
    ifc.core_addr  = 10'($urandom_range(0, 1023));
    ifc.core_done  = 1'b0;
    ifc.core_digit = 4'h0;
    ifc.tx_busy    = 1'b0;
    modelReset();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    checkResetState("reset");

    // Stray core_done while idle must be ignored.
    tick();
    ifc.core_digit = 4'h5;
    ifc.core_done  = 1'b1;
    tick();
    ifc.core_done  = 1'b0;
    @(negedge clk);
    checkOutput("idle_done_busy", 32'(ifc.busy), 0);
    checkOutput("idle_done_txdata", 32'(ifc.tx_data), 32'h30);
    tick();
    clearLog();

    // Image A: first byte A5 inspected on its own, then the rest; digit 7, tx free.
    applyStimulus(8'hA5, 12);
    @(negedge clk);
    checkOutput("a5_write_count", 32'(wrAddr.size()), 8);
    for (int k = 0; k < 8 && k < wrAddr.size(); k++) begin
      checkOutput("a5_addr", wrAddr[k], 32'(k));
      checkOutput("a5_data", wrData[k], 32'(expPix(k)));
      checkOutput("a5_cycle", 32'(wrCyc[k]), 32'(lastDriveCyc + 1 + k));
    end
    checkOutput("a5_busy_waitb", 32'(ifc.busy), 1);
    checkOutput("a5_we_waitb", 32'(ifc.ram_we), 0);
    tick();
    feedUntil(NBYTES);
    finishImage("imgA", 4'd7, 0, 1'b0);

    // Image B: tx held busy for 50 cycles and a byte thrown in during classification.
    feedUntil(NBYTES);
    finishImage("imgB", 4'($urandom_range(0, 9)), 50, 1'b1);

    // Image C: fresh reset, then a too-early byte, then 40 bytes and a reset mid-shift.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    modelReset();
    clearLog();
    applyStimulus(8'($urandom), 3);
    applyStimulus(8'($urandom), 10);
    @(negedge clk);
    checkOutput("drop_overrun", 32'(ifc.overrun), 32'(modelOverrun));
    checkOutput("drop_write_count", 32'(wrAddr.size()), 8);
    tick();
    feedUntil(40);
    tick();
    verifyImageLog("imgC");
    applyStimulus(8'($urandom), 3);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    modelReset();
    checkResetState("midreset");
    tick();
    clearLog();

    // Image D: full image after the abort must restart at address 0.
    feedUntil(NBYTES);
    finishImage("imgD", 4'($urandom_range(0, 9)), int'($urandom_range(1, 6)), 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
